// File: rtl/ldm_stm_seq_pkg.sv
// ldm_stm_pkg: shared definitions for the LDM/STM block-transfer sequencer.
//   state_t  - sequencer FSM states (IDLE, CALC, XFER, WB, DONE)
//   amode_t  - addressing modes, encoded as {pre, up}
//   REG_PC   - architectural register number of the program counter
//   REG_W    - register-number width
package ldm_stm_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] REG_PC = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_XFER = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Encoding is {P, U} straight from the instruction bits.
  typedef enum logic [1:0] {
    AM_DA = 2'b00,
    AM_IA = 2'b01,
    AM_DB = 2'b10,
    AM_IB = 2'b11
  } amode_t;

endpackage

// File: rtl/ldm_stm_seq_if.sv
// ldm_stm_seq_if: memory word-transfer bus plus register-file ports of the
// LDM/STM sequencer.
//   mem_req/mem_we/mem_addr/mem_wdata  sequencer -> memory
//   mem_ready/mem_rdata                memory -> sequencer
//   rf_ra                              sequencer -> register file read address
//   rf_rd                              register file -> sequencer read data
//   rf_we/rf_wa/rf_wd                  sequencer -> register file write port
// Modports: master (sequencer side), slave (memory/register-file side).
interface ldm_stm_seq_if
  import ldm_stm_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [REG_W-1:0]  rf_ra;
  logic [DATA_W-1:0] rf_rd;
  logic              rf_we;
  logic [REG_W-1:0]  rf_wa;
  logic [DATA_W-1:0] rf_wd;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, rf_ra, rf_we, rf_wa, rf_wd,
    input  mem_ready, mem_rdata, rf_rd
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, rf_ra, rf_we, rf_wa, rf_wd,
    output mem_ready, mem_rdata, rf_rd
  );

endinterface

// File: rtl/ldm_stm_seq_reglist_scan.sv
// reglist_scan: combinational scan of a register list.
//   list  in   NREGS        register list, bit i = register i
//   idx   out  clog2(NREGS) index of the lowest set bit (0 when list is empty)
//   cnt   out  clog2+1      number of set bits
module reglist_scan
  import ldm_stm_pkg::*;
#(
  parameter int NREGS = 16,
  localparam int IDX_W = $clog2(NREGS),
  localparam int CNT_W = $clog2(NREGS) + 1
) (
  input  logic [NREGS-1:0] list,
  output logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    idx = '0;
    cnt = '0;
    // Walking downwards leaves the lowest set bit as the final assignment.
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (list[i]) idx = IDX_W'(i);
    end
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + CNT_W'(list[i]);
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: multi-cycle sequencer for ARM LDM/STM block transfers.
// Walks the latched register list lowest-register-first, one memory word per
// set bit at ascending addresses, then optionally writes the final base back.
//   clk, reset                  clock (rising edge), async active-high reset
//   start                       launch, sampled only in IDLE
//   load/pre/up/wback           LDM vs STM, P, U and W bits (latched at start)
//   base_reg, base, reglist     base register number/value, register list
//   bus (master)                memory bus and register-file ports
//   pc_we, pc_wd                PC write for loads / writeback targeting r15
//   busy, done                  busy while sequencing; one-cycle done pulse
module ldm_stm_seq
  import ldm_stm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load,
  input  logic               pre,
  input  logic               up,
  input  logic               wback,
  input  logic [REG_W-1:0]   base_reg,
  input  logic [DATA_W-1:0]  base,
  input  logic [NREGS-1:0]   reglist,
  ldm_stm_seq_if.master      bus,
  output logic               pc_we,
  output logic [DATA_W-1:0]  pc_wd,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = $clog2(NREGS);
  localparam int CNT_W = $clog2(NREGS) + 1;

  state_t             state;
  logic               load_l;
  logic               wback_l;
  amode_t             mode_l;
  logic [REG_W-1:0]   base_reg_l;
  logic [NREGS-1:0]   list_l;
  logic [NREGS-1:0]   rem;
  logic [DATA_W-1:0]  base_l;
  logic [DATA_W-1:0]  addr;
  logic [DATA_W-1:0]  final_base;

  logic [IDX_W-1:0]   cur_idx;
  logic [CNT_W-1:0]   cnt;
  logic [NREGS-1:0]   rem_clr;
  logic               xfer, st_x, ld_hit, wb_st;

  // In CALC rem still equals the full list, so cnt there is N.
  reglist_scan #(.NREGS(NREGS)) u_scan (
    .list (rem),
    .idx  (cur_idx),
    .cnt  (cnt)
  );

  function automatic logic [DATA_W-1:0] span_of(input logic [CNT_W-1:0] n);
    span_of = DATA_W'(n) << 2;
  endfunction

  // Lowest address touched; transfers always ascend from here.
  function automatic logic [DATA_W-1:0] first_addr(input logic [DATA_W-1:0] b,
                                                   input logic [CNT_W-1:0]  n,
                                                   input amode_t            m);
    case (m)
      AM_IA:   first_addr = b;
      AM_IB:   first_addr = b + DATA_W'(4);
      AM_DA:   first_addr = b - span_of(n) + DATA_W'(4);
      default: first_addr = b - span_of(n);
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] end_base(input logic [DATA_W-1:0] b,
                                                 input logic [CNT_W-1:0]  n,
                                                 input logic              u);
    end_base = u ? (b + span_of(n)) : (b - span_of(n));
  endfunction

  assign rem_clr = rem & ~(NREGS'(1) << cur_idx);

  // Control state: FSM and latched instruction fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      load_l     <= 1'b0;
      wback_l    <= 1'b0;
      mode_l     <= AM_DA;
      base_reg_l <= '0;
      list_l     <= '0;
      rem        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            load_l     <= load;
            wback_l    <= wback;
            mode_l     <= amode_t'({pre, up});
            base_reg_l <= base_reg;
            list_l     <= reglist;
            rem        <= reglist;
            state      <= S_CALC;
          end
        end
        S_CALC: state <= (rem == '0) ? S_DONE : S_XFER;
        S_XFER: begin
          if (bus.mem_ready) begin
            rem <= rem_clr;
            if (rem_clr == '0) begin
              // A loaded base register overrides the writeback value.
              state <= (wback_l && !(load_l && list_l[base_reg_l])) ? S_WB : S_DONE;
            end
          end
        end
        S_WB:    state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address datapath: outputs are gated by state, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) base_l <= base;
    if (state == S_CALC) begin
      addr       <= first_addr(base_l, cnt, mode_l);
      final_base <= end_base(base_l, cnt, mode_l[0]);
    end
    if (state == S_XFER && bus.mem_ready) addr <= addr + DATA_W'(4);
  end

  assign xfer   = (state == S_XFER);
  assign st_x   = xfer & ~load_l;
  assign ld_hit = xfer & load_l & bus.mem_ready;
  assign wb_st  = (state == S_WB);

  always_comb begin
    bus.mem_req   = xfer;
    bus.mem_we    = st_x;
    bus.mem_addr  = xfer ? {addr[DATA_W-1:2], 2'b00} : '0;
    bus.mem_wdata = st_x ? bus.rf_rd : '0;
    bus.rf_ra     = st_x ? REG_W'(cur_idx) : '0;
    bus.rf_we     = 1'b0;
    bus.rf_wa     = '0;
    bus.rf_wd     = '0;
    pc_we         = 1'b0;
    pc_wd         = '0;
    // r15 is never written through the register-file port.
    if (ld_hit) begin
      if (REG_W'(cur_idx) == REG_PC) begin
        pc_we = 1'b1;
        pc_wd = bus.mem_rdata;
      end else begin
        bus.rf_we = 1'b1;
        bus.rf_wa = REG_W'(cur_idx);
        bus.rf_wd = bus.mem_rdata;
      end
    end else if (wb_st) begin
      if (base_reg_l == REG_PC) begin
        pc_we = 1'b1;
        pc_wd = final_base;
      end else begin
        bus.rf_we = 1'b1;
        bus.rf_wa = base_reg_l;
        bus.rf_wd = final_base;
      end
    end
    busy = (state == S_CALC) || (state == S_XFER) || (state == S_WB);
    done = (state == S_DONE);
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq: directed and randomized bench for ldm_stm_seq. The expected
// behaviour of each transfer is derived from the list, base and mode with
// plain arithmetic and compared cycle by cycle on the falling clock edge.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, load, pre, up, wback;
  logic [3:0]  base_reg;
  logic [31:0] base;
  logic [15:0] reglist;
  logic        pc_we, busy, done;
  logic [31:0] pc_wd;

  int total = 0;
  int bad   = 0;

  ldm_stm_seq_if #(.DATA_W(32)) bus ();

  ldm_stm_seq #(.DATA_W(32), .NREGS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load     (load),
    .pre      (pre),
    .up       (up),
    .wback    (wback),
    .base_reg (base_reg),
    .base     (base),
    .reglist  (reglist),
    .bus      (bus),
    .pc_we    (pc_we),
    .pc_wd    (pc_wd),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_req"},   32'(bus.mem_req),   0);
    chk({tag, ".mem_we"},    32'(bus.mem_we),    0);
    chk({tag, ".mem_addr"},  bus.mem_addr,       0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata,      0);
    chk({tag, ".rf_ra"},     32'(bus.rf_ra),     0);
    chk({tag, ".rf_we"},     32'(bus.rf_we),     0);
    chk({tag, ".rf_wa"},     32'(bus.rf_wa),     0);
    chk({tag, ".rf_wd"},     bus.rf_wd,          0);
    chk({tag, ".pc_we"},     32'(pc_we),         0);
    chk({tag, ".pc_wd"},     pc_wd,              0);
    chk({tag, ".busy"},      32'(busy),          0);
    chk({tag, ".done"},      32'(done),          0);
  endtask

  // One complete LDM/STM operation checked against the reference behaviour.
  task automatic run_op(input string nm, input bit ld, input bit p, input bit u,
                        input bit wb, input logic [3:0] br, input logic [31:0] b,
                        input logic [15:0] lst, input int rdy_pct,
                        input bit fix_rd, input logic [31:0] rd_val);
    logic [3:0]  regs[$];
    int          n, k, waits, cyc, stage;
    logic [31:0] span, first, fin, rdv, rfv, ewd;
    logic [3:0]  ewa;
    bit          exp_wb, rdy, finished, erfwe, epcwe;

    regs.delete();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        regs.push_back(4'(i));
        n++;
      end
    end
    span   = 32'(n) * 32'd4;
    first  = u ? (p ? b + 32'd4 : b) : (p ? b - span : b - span + 32'd4);
    fin    = u ? b + span : b - span;
    exp_wb = wb && (n > 0) && !(ld && lst[br]);

    @(posedge clk); #1;
    start = 1'b1; load = ld; pre = p; up = u; wback = wb;
    base_reg = br; base = b; reglist = lst;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble the inputs: the sequencer must work from its latched copy.
    start = 1'b0; load = ~ld; pre = ~p; up = ~u; wback = ~wb;
    base_reg = 4'($urandom); base = $urandom; reglist = 16'($urandom);

    stage = 0; k = 0; waits = 0; cyc = 0; finished = 1'b0;
    while (!finished && cyc < 300) begin
      cyc++;
      rdy = ($urandom_range(99) < rdy_pct);
      rdv = fix_rd ? rd_val : $urandom;
      rfv = $urandom;
      bus.mem_ready = rdy;
      bus.mem_rdata = rdv;
      bus.rf_rd     = rfv;
      @(negedge clk);
      chk({nm, ".busy"},    32'(busy),        32'(stage != 3));
      chk({nm, ".done"},    32'(done),        32'(stage == 3));
      chk({nm, ".mem_req"}, 32'(bus.mem_req), 32'(stage == 1));
      erfwe = 1'b0; epcwe = 1'b0; ewa = '0; ewd = '0;
      if (stage == 1) begin
        chk({nm, ".mem_we"},   32'(bus.mem_we), 32'(!ld));
        chk({nm, ".mem_addr"}, bus.mem_addr, (first + 32'(k) * 32'd4) & ~32'd3);
        if (!ld) begin
          chk({nm, ".rf_ra"},     32'(bus.rf_ra), 32'(regs[k]));
          chk({nm, ".mem_wdata"}, bus.mem_wdata,  rfv);
        end else if (rdy) begin
          if (regs[k] == 4'd15) begin
            epcwe = 1'b1; ewd = rdv;
          end else begin
            erfwe = 1'b1; ewa = regs[k]; ewd = rdv;
          end
        end
      end else if (stage == 2) begin
        if (br == 4'd15) begin
          epcwe = 1'b1; ewd = fin;
        end else begin
          erfwe = 1'b1; ewa = br; ewd = fin;
        end
      end
      chk({nm, ".rf_we"}, 32'(bus.rf_we), 32'(erfwe));
      chk({nm, ".pc_we"}, 32'(pc_we),     32'(epcwe));
      if (erfwe) begin
        chk({nm, ".rf_wa"}, 32'(bus.rf_wa), 32'(ewa));
        chk({nm, ".rf_wd"}, bus.rf_wd,      ewd);
      end
      if (epcwe) chk({nm, ".pc_wd"}, pc_wd, ewd);
      if (stage == 3) begin
        chk({nm, ".latency"}, 32'(cyc), 32'(2 + n + waits + (exp_wb ? 1 : 0)));
        finished = 1'b1;
      end
      case (stage)
        0: stage = (n == 0) ? 3 : 1;
        1: begin
          if (rdy) begin
            k++;
            if (k == n) stage = exp_wb ? 2 : 3;
          end else begin
            waits++;
          end
        end
        2: stage = 3;
        default: ;
      endcase
      @(posedge clk); #1;
    end
    if (!finished) chk({nm, ".timeout"}, 32'd0, 32'd1);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk({nm, ".idle_busy"}, 32'(busy),        0);
    chk({nm, ".idle_done"}, 32'(done),        0);
    chk({nm, ".idle_req"},  32'(bus.mem_req), 0);
  endtask

  initial begin
    logic [15:0] rl;
    reset = 1'b1;
    start = 1'b0; load = 1'b0; pre = 1'b0; up = 1'b0; wback = 1'b0;
    base_reg = '0; base = '0; reglist = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.rf_rd = 32'h1234_5678;
    @(negedge clk);
    chk_zero("reset0");
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("t1_stm_ia",     1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  32'h100, 16'h000B, 100, 1'b0, 32'h0);
    run_op("t2_ldm_db_wb",  1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h00F0, 100, 1'b0, 32'h0);
    run_op("t3_ldm_ia_pc",  1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  32'h400, 16'h8001, 100, 1'b1, 32'hDEAD_0000);
    run_op("t4_ldm_ib_own", 1'b1, 1'b1, 1'b1, 1'b1, 4'd2,  32'h500, 16'h0004, 100, 1'b0, 32'h0);
    run_op("t5_empty",      1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  32'h600, 16'h0000, 100, 1'b0, 32'h0);
    run_op("t7_stm_da_pc",  1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 32'h800, 16'h1234, 50,  1'b0, 32'h0);
    run_op("t8_wrap_db",    1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  32'h4,   16'h0F00, 70,  1'b0, 32'h0);

    // Stall mid-transfer, then reset; start during reset must not launch.
    @(posedge clk); #1;
    start = 1'b1; load = 1'b0; pre = 1'b0; up = 1'b1; wback = 1'b1;
    base_reg = 4'd5; base = 32'h300; reglist = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_stall_req",  32'(bus.mem_req), 1);
      chk("t6_stall_addr", bus.mem_addr,     32'h300);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    bus.rf_rd = 32'hCAFE_F00D;
    bus.mem_ready = 1'b1;
    #1;
    chk_zero("t6_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = (i == 1);
      @(negedge clk);
      chk("t6_rst_busy", 32'(busy),        0);
      chk("t6_rst_req",  32'(bus.mem_req), 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_after_busy",  32'(busy),        0);
      chk("t6_after_req",   32'(bus.mem_req), 0);
      chk("t6_after_rf_we", 32'(bus.rf_we),   0);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(3))
        0:       rl = 16'h0000;
        1:       rl = 16'h0001 << $urandom_range(15);
        default: rl = 16'($urandom);
      endcase
      run_op($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 4'($urandom), $urandom, rl, 60, 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
